// File: rtl/seg_bcd_scan.sv
// Six-digit multiplexed seven-segment driver with brightness PWM and input shadowing.
// Optional leading-zero blanking is enabled by defining SEG_LZ_BLANK_EN.
module seg_bcd_scan #(
  parameter int SCAN_DIV = 50_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [23:0] bcd_in,
  input  logic [5:0]  dp,
  input  logic [3:0]  brightness,
  output logic [5:0]  seg_sel,
  output logic [7:0]  seg_data
);

  localparam int PWM_STEP = SCAN_DIV / 16;
  localparam int SW       = $clog2(SCAN_DIV);
  localparam int PW       = (PWM_STEP > 1) ? $clog2(PWM_STEP) : 1;
  localparam logic [SW-1:0] SLOT_LAST = SW'(SCAN_DIV - 1);
  localparam logic [PW-1:0] PWM_LAST  = PW'(PWM_STEP - 1);

  logic [SW-1:0] r_slotCnt;
  logic [PW-1:0] r_pwmDiv;
  logic [3:0]    r_pwmCnt;
  logic [2:0]    r_scanIdx;
  logic [23:0]   r_bcd;
  logic [5:0]    r_dp;
  logic [3:0]    r_bri;

  logic          w_slotEnd;
  logic [3:0]    w_nibble;
  logic          w_dpOn;
  logic          w_blank;
  logic [5:0]    w_lzMask;
  logic          w_active;

  function automatic logic [6:0] decodeGlyph(input logic [3:0] v);
    logic [6:0] g;
    case (v)
      4'h0: g = 7'h40;
      4'h1: g = 7'h79;
      4'h2: g = 7'h24;
      4'h3: g = 7'h30;
      4'h4: g = 7'h19;
      4'h5: g = 7'h12;
      4'h6: g = 7'h02;
      4'h7: g = 7'h78;
      4'h8: g = 7'h00;
      4'h9: g = 7'h10;
      4'hA: g = 7'h08;
      4'hB: g = 7'h03;
      4'hC: g = 7'h46;
      4'hD: g = 7'h21;
      4'hE: g = 7'h06;
      default: g = 7'h0E;
    endcase
    return g;
  endfunction

  assign w_slotEnd = (r_slotCnt == SLOT_LAST);
  assign w_active  = (r_pwmCnt <= r_bri);

`ifdef SEG_LZ_BLANK_EN
  // A digit is blank only if it and every more-significant digit are zero.
  assign w_lzMask[5] = (r_bcd[23:20] == 4'h0);
  assign w_lzMask[4] = w_lzMask[5] & (r_bcd[19:16] == 4'h0);
  assign w_lzMask[3] = w_lzMask[4] & (r_bcd[15:12] == 4'h0);
  assign w_lzMask[2] = w_lzMask[3] & (r_bcd[11:8]  == 4'h0);
  assign w_lzMask[1] = w_lzMask[2] & (r_bcd[7:4]   == 4'h0);
  assign w_lzMask[0] = 1'b0;
`else
  assign w_lzMask = 6'b000000;
`endif

  // Scan index 0 shows the most significant digit (digit 5).
  always_comb begin
    w_nibble = 4'h0;
    w_dpOn   = 1'b0;
    w_blank  = 1'b0;
    case (r_scanIdx)
      3'd0: begin w_nibble = r_bcd[23:20]; w_dpOn = r_dp[5]; w_blank = w_lzMask[5]; end
      3'd1: begin w_nibble = r_bcd[19:16]; w_dpOn = r_dp[4]; w_blank = w_lzMask[4]; end
      3'd2: begin w_nibble = r_bcd[15:12]; w_dpOn = r_dp[3]; w_blank = w_lzMask[3]; end
      3'd3: begin w_nibble = r_bcd[11:8];  w_dpOn = r_dp[2]; w_blank = w_lzMask[2]; end
      3'd4: begin w_nibble = r_bcd[7:4];   w_dpOn = r_dp[1]; w_blank = w_lzMask[1]; end
      3'd5: begin w_nibble = r_bcd[3:0];   w_dpOn = r_dp[0]; w_blank = w_lzMask[0]; end
      default: begin w_nibble = 4'h0; w_dpOn = 1'b0; w_blank = 1'b0; end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_slotCnt <= '0;
      r_pwmDiv  <= '0;
      r_pwmCnt  <= 4'd0;
      r_scanIdx <= 3'd0;
      r_bcd     <= 24'h0;
      r_dp      <= 6'h0;
      r_bri     <= 4'd0;
    end else if (w_slotEnd) begin
      r_slotCnt <= '0;
      r_pwmDiv  <= '0;
      r_pwmCnt  <= 4'd0;
      r_scanIdx <= (r_scanIdx == 3'd5) ? 3'd0 : r_scanIdx + 3'd1;
      r_bcd     <= bcd_in;
      r_dp      <= dp;
      r_bri     <= brightness;
    end else begin
      r_slotCnt <= r_slotCnt + 1'b1;
      if (r_pwmDiv == PWM_LAST) begin
        r_pwmDiv <= '0;
        r_pwmCnt <= r_pwmCnt + 4'd1;
      end else begin
        r_pwmDiv <= r_pwmDiv + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_sel  <= 6'h3F;
      seg_data <= 8'hFF;
    end else if (w_active) begin
      seg_sel  <= ~(6'b000001 << r_scanIdx);
      seg_data <= {~w_dpOn, (w_blank ? 7'h7F : decodeGlyph(w_nibble))};
    end else begin
      seg_sel  <= 6'h3F;
      seg_data <= 8'hFF;
    end
  end

endmodule

// File: tb/tb_seg_bcd_scan.sv
// Scoreboard bench for seg_bcd_scan at SCAN_DIV=32: the driver queues one expected
// burst (select, pattern, active length) per slot and a monitor matches DUT bursts.
module tb_seg_bcd_scan;

  localparam int SCAN_DIV = 32;
  localparam int PWM_STEP = SCAN_DIV / 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [23:0] bcd_in = 24'h0;
  logic [5:0]  dp = 6'h0;
  logic [3:0]  brightness = 4'd0;
  logic [5:0]  seg_sel;
  logic [7:0]  seg_data;

  typedef struct {
    logic [5:0] sel;
    logic [7:0] data;
    int         len;
  } exp_t;

  exp_t expQ[$];
  int   nChecks = 0;
  int   nPass = 0;
  int   benchIdx = 0;

  logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  seg_bcd_scan #(.SCAN_DIV(SCAN_DIV)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bcd_in     (bcd_in),
    .dp         (dp),
    .brightness (brightness),
    .seg_sel    (seg_sel),
    .seg_data   (seg_data)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nChecks++;
    if (actual === expected) nPass++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
  endtask

  function automatic exp_t expFor(input int idx, input logic [23:0] bcd, input logic [5:0] dpv,
                                  input logic [3:0] bri);
    exp_t e;
    int k;
    logic [3:0] nib;
    logic blank;
    logic [5:0] oneHot;
    k = 5 - idx;
    nib = bcd[4*k +: 4];
    blank = 1'b0;
`ifdef SEG_LZ_BLANK_EN
    blank = (k != 0);
    for (int j = k; j <= 5; j++) if (bcd[4*j +: 4] != 4'h0) blank = 1'b0;
`endif
    oneHot = 6'b000001 << idx;
    e.sel  = ~oneHot;
    e.data = {~dpv[k], (blank ? 7'h7F : glyph[nib])};
    e.len  = PWM_STEP * (int'(bri) + 1);
    return e;
  endfunction

  // Called at the falling edge just before a slot's first output edge; the inputs
  // are captured at the end of this slot and shown for the next n slots.
  task automatic applyStimulus(input logic [23:0] bcd, input logic [5:0] dpv,
                               input logic [3:0] bri, input int n);
    bcd_in = bcd;
    dp = dpv;
    brightness = bri;
    for (int s = 1; s <= n; s++) expQ.push_back(expFor((benchIdx + s) % 6, bcd, dpv, bri));
    benchIdx = (benchIdx + n) % 6;
    repeat (SCAN_DIV * n) @(negedge clk);
  endtask

  task automatic releaseReset();
    @(negedge clk);
    rst_n = 1'b1;
    benchIdx = 0;
    expQ.push_back(expFor(0, 24'h0, 6'h0, 4'd0));
  endtask

  task automatic assertResetMidSlot(input string tag);
    repeat (15) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput({tag, "_sel_async"}, 32'(seg_sel), 32'h3F);
    checkOutput({tag, "_data_async"}, 32'(seg_data), 32'hFF);
    repeat (3) @(negedge clk);
    checkOutput({tag, "_sel_held"}, 32'(seg_sel), 32'h3F);
    checkOutput({tag, "_data_held"}, 32'(seg_data), 32'hFF);
  endtask

  // Monitor: every new active digit select starts a burst that must match the queue head.
  initial begin : monitor
    bit   inBurst = 0;
    bit   stable = 1;
    int   len = 0;
    exp_t cur;
    logic [7:0] curData;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        inBurst = 0;
      end else if (seg_sel != 6'h3F) begin
        if (!inBurst || seg_sel != cur.sel) begin
          if (inBurst) begin
            checkOutput("burst_len", 32'(len), 32'(cur.len));
            checkOutput("burst_stable", 32'(stable), 32'd1);
          end
          if (expQ.size() == 0) begin
            checkOutput("unexpected_burst", 32'(seg_sel), 32'h3F);
            inBurst = 0;
          end else begin
            cur = expQ.pop_front();
            checkOutput("seg_sel", 32'(seg_sel), 32'(cur.sel));
            checkOutput("seg_data", 32'(seg_data), 32'(cur.data));
            inBurst = 1;
            len = 1;
            stable = 1;
            curData = seg_data;
          end
        end else begin
          len++;
          if (seg_data != curData) stable = 0;
        end
      end else begin
        if (inBurst) begin
          checkOutput("burst_len", 32'(len), 32'(cur.len));
          checkOutput("burst_stable", 32'(stable), 32'd1);
        end
        inBurst = 0;
        checkOutput("idle_data", 32'(seg_data), 32'hFF);
      end
    end
  end

  initial begin : driver
    repeat (3) @(negedge clk);
    checkOutput("reset_sel", 32'(seg_sel), 32'h3F);
    checkOutput("reset_data", 32'(seg_data), 32'hFF);
    releaseReset();

    applyStimulus(24'h123456, 6'h00, 4'd15, 7);
    applyStimulus(24'h123456, 6'h00, 4'd3, 2);
    applyStimulus(24'h123456, 6'h00, 4'd0, 2);
    applyStimulus(24'h987654, 6'b101010, 4'd15, 6);
    applyStimulus(24'hABCDEF, 6'h00, 4'd15, 6);
    applyStimulus(24'h000000, 6'h00, 4'd15, 6);
    applyStimulus(24'h000102, 6'b000100, 4'd15, 6);

    // Change the inputs ten clocks into a slot: only the following slot may see them.
    applyStimulus(24'h111111, 6'h00, 4'd15, 1);
    repeat (10) @(negedge clk);
    bcd_in = 24'h222222;
    expQ.push_back(expFor((benchIdx + 1) % 6, 24'h222222, 6'h00, 4'd15));
    benchIdx = (benchIdx + 1) % 6;
    repeat (SCAN_DIV - 10) @(negedge clk);

    applyStimulus(24'h222222, 6'h00, 4'd15, 2);
    assertResetMidSlot("midreset");
    releaseReset();
    applyStimulus(24'h123456, 6'h3F, 4'd3, 3);

    repeat (12) @(negedge clk);
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("queue_drained", 32'(expQ.size()), 32'd0);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
